// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box table, GF(2^8) arithmetic and the iterative FSM encoding.
package aes_pkg;

   localparam int BLOCK_W      = 128;
   localparam int NR_NK_OFFSET = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } aesState_e;

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic bit nrValid(input int nk, input int nr);
      return ((nk == 4) || (nk == 6) || (nk == 8)) && (nr == nk + NR_NK_OFFSET);
   endfunction

   // Entry x sits at byte (255 - x) counting from the LSB, and 255 - x == ~x.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TABLE[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_enc_round
   import aes_pkg::*;
(
   input  logic [BLOCK_W-1:0] state,
   input  logic [BLOCK_W-1:0] round_key,
   input  logic               is_final,
   output logic [BLOCK_W-1:0] next_state
);

   logic [7:0] subB   [16];
   logic [7:0] shiftB [16];
   logic [7:0] mixB   [16];

   // Byte i of the block is column i/4, row i%4; byte 0 is the top of the bus.
   for (genvar i = 0; i < 16; i++) begin : gSub
      assign subB[i] = sbox(state[BLOCK_W-1-8*i -: 8]);
   end

   for (genvar c = 0; c < 4; c++) begin : gShiftCol
      for (genvar r = 0; r < 4; r++) begin : gShiftRow
         assign shiftB[r + 4*c] = subB[r + 4*((c + r) % 4)];
      end
   end

   for (genvar c = 0; c < 4; c++) begin : gMix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = shiftB[4*c];
      assign a1 = shiftB[4*c + 1];
      assign a2 = shiftB[4*c + 2];
      assign a3 = shiftB[4*c + 3];
      assign mixB[4*c]     = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      assign mixB[4*c + 1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      assign mixB[4*c + 2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      assign mixB[4*c + 3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
   end

   for (genvar i = 0; i < 16; i++) begin : gKey
      assign next_state[BLOCK_W-1-8*i -: 8] =
         (is_final ? shiftB[i] : mixB[i]) ^ round_key[BLOCK_W-1-8*i -: 8];
   end

endmodule

// File: rtl/aes_encipher_iter.sv
// Iterative AES encryptor: one round per clock against a flat pre-expanded key schedule,
// valid/ready handshakes on both the plaintext and ciphertext sides.
module aes_encipher_iter
   import aes_pkg::*;
#(
   parameter int Nk = 4,
   parameter int Nr = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [BLOCK_W-1:0]        in_data,
   input  logic [BLOCK_W*(Nr+1)-1:0] word,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [BLOCK_W-1:0]        out_data,
   output logic                      busy
);

   if (!nrValid(Nk, Nr)) begin : gBadParams
      $error("aes_encipher_iter: Nk must be 4/6/8 and Nr must equal Nk+6");
   end

   localparam logic [3:0] LAST_ROUND = 4'(Nr);

   aesState_e          fsmCur;
   aesState_e          fsmNxt;
   logic [3:0]         roundCnt;
   logic [BLOCK_W-1:0] stateReg;
   logic [BLOCK_W-1:0] roundKey;
   logic [BLOCK_W-1:0] roundOut;
   logic               lastRound;

   assign lastRound = (roundCnt == LAST_ROUND);

   // Gated with rst_n so the block advertises nothing while held in reset.
   assign in_ready = (fsmCur == IDLE) && rst_n;

   always_comb begin
      roundKey = '0;
      for (int r = 0; r <= Nr; r++) begin
         if (roundCnt == 4'(r)) roundKey = word[BLOCK_W*r +: BLOCK_W];
      end
   end

   aes_enc_round u_round (
      .state      (stateReg),
      .round_key  (roundKey),
      .is_final   (lastRound),
      .next_state (roundOut)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fsmCur <= IDLE;
      else        fsmCur <= fsmNxt;
   end

   always_comb begin
      fsmNxt = fsmCur;
      case (fsmCur)
         IDLE:    if (in_valid)  fsmNxt = RUN;
         RUN:     if (lastRound) fsmNxt = DONE;
         DONE:    if (out_ready) fsmNxt = IDLE;
         default: fsmNxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         roundCnt  <= 4'd0;
         stateReg  <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (fsmCur)
            IDLE: begin
               if (in_valid) begin
                  stateReg <= in_data ^ word[BLOCK_W-1:0];
                  roundCnt <= 4'd1;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               stateReg <= roundOut;
               if (lastRound) begin
                  out_data  <= roundOut;
                  out_valid <= 1'b1;
                  roundCnt  <= 4'd0;
               end else begin
                  roundCnt <= roundCnt + 4'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_encipher_iter.sv
// Scoreboarded bench for aes_encipher_iter: AES-128 and AES-256 instances against a
// behavioural AES model built from GF(2^8) arithmetic.
module tb_aes_encipher_iter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         inValid  [2];
   logic         inReady  [2];
   logic         outValid [2];
   logic         outReady [2];
   logic         busy     [2];
   logic [127:0] inData   [2];
   logic [127:0] outData  [2];
   logic [128*11-1:0] word0;
   logic [128*15-1:0] word1;

   aes_encipher_iter #(.Nk(4), .Nr(10)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(inValid[0]), .in_ready(inReady[0]),
      .in_data(inData[0]), .word(word0), .out_valid(outValid[0]),
      .out_ready(outReady[0]), .out_data(outData[0]), .busy(busy[0]));

   aes_encipher_iter #(.Nk(8), .Nr(14)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(inValid[1]), .in_ready(inReady[1]),
      .in_data(inData[1]), .word(word1), .out_valid(outValid[1]),
      .out_ready(outReady[1]), .out_data(outData[1]), .busy(busy[1]));

   typedef struct {
      int           lane;
      logic [127:0] exp;
      int           acceptEdge;
      string        nm;
   } sbEntry_t;

   sbEntry_t   sbQ[$];
   int         nVec = 0;
   int         nErr = 0;
   int         cyc  = 0;
   logic [7:0] sb[256];
   logic       prevOv[2];

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] d = {v, v};
      return d[15-n -: 8];
   endfunction

   task automatic buildSbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subW(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   function automatic logic [1919:0] expandKey(input logic [255:0] key, input int nk);
      logic [31:0]   w[60];
      logic [31:0]   t;
      logic [7:0]    rc = 8'h01;
      logic [1919:0] flat = '0;
      int            nr = nk + 6;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subW({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gm(rc, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            t = subW(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r <= nr; r++) flat[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      return flat;
   endfunction

   function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1919:0] ks, input int nr);
      logic [7:0]   s[16];
      logic [7:0]   t[16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] rk;
      logic [127:0] res;
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ ks[127-8*i -: 8];
      for (int r = 1; r <= nr; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) s[w + 4*c] = t[w + 4*((c + w) % 4)];
         if (r < nr) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
               s[4*c+3] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
            end
         end
         rk = ks[128*r +: 128];
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   function automatic int nrOf(input int l);
      return (l == 0) ? 10 : 14;
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      nVec++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      for (int l = 0; l < 2; l++) begin
         if (outValid[l] === 1'b1 && prevOv[l] !== 1'b1) begin
            if (sbQ.size() == 0 || sbQ[0].lane != l) begin
               nVec++;
               nErr++;
               $display("FAIL unexpected_output lane %0d: out_valid rose with data %h, expected no block pending", l, outData[l]);
            end else begin
               check($sformatf("%s latency", sbQ[0].nm), 128'(cyc - sbQ[0].acceptEdge), 128'(nrOf(l)));
            end
         end
         if (outValid[l] === 1'b1 && outReady[l] && sbQ.size() != 0 && sbQ[0].lane == l) begin
            check($sformatf("%s data", sbQ[0].nm), outData[l], sbQ[0].exp);
            void'(sbQ.pop_front());
         end
         prevOv[l] = outValid[l];
      end
   end

   // ---------------- stimulus ----------------
   task automatic sendBlock(input int l, input logic [127:0] pt, input logic [127:0] exp,
                            input string nm, input bit keepValid, output int accEdge);
      sbEntry_t e;
      bit ok = 0;
      inValid[l] = 1'b1;
      inData[l]  = pt;
      accEdge    = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (inReady[l]) begin ok = 1; break; end
      end
      if (!ok) begin
         nVec++;
         nErr++;
         $display("FAIL %s accept_timeout: in_ready stayed 0, expected 1 within 200 cycles", nm);
         inValid[l] = 1'b0;
         return;
      end
      accEdge      = cyc + 1;
      e.lane       = l;
      e.exp        = exp;
      e.acceptEdge = accEdge;
      e.nm         = nm;
      sbQ.push_back(e);
      @(posedge clk); #1;
      if (!keepValid) inValid[l] = 1'b0;
   endtask

   task automatic waitDrain(input string nm);
      for (int i = 0; i < 300 && sbQ.size() != 0; i++) @(posedge clk);
      if (sbQ.size() != 0) begin
         nVec++;
         nErr++;
         $display("FAIL %s drain_timeout: %0d blocks outstanding, expected 0", nm, sbQ.size());
         sbQ.delete();
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running at time limit, expected finish");
      $fatal(1, "watchdog expired");
   end

   localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] EXP_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] EXP_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] EXP_B  = 128'h3925841d02dc09fbdc118597196a0b32;

   initial begin
      logic [1919:0] ks0;
      logic [1919:0] ks1;
      logic [127:0]  held;
      logic [127:0]  pt;
      logic [127:0]  key;
      int            acc;
      int            prevAcc;
      bit            seen;

      rst_n = 1'b0;
      prevOv = '{1'b0, 1'b0};
      for (int l = 0; l < 2; l++) begin
         inValid[l] = 1'b0; inData[l] = '0; outReady[l] = 1'b1;
      end
      buildSbox();
      ks0   = expandKey({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
      ks1   = expandKey(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
      word0 = ks0[128*11-1:0];
      word1 = ks1;

      repeat (3) @(posedge clk); #1;
      check("reset in_ready", 128'(inReady[0]), 128'(0));
      check("reset out_valid", 128'(outValid[0]), 128'(0));
      check("reset busy", 128'(busy[0]), 128'(0));
      check("reset out_data", outData[0], 128'h0);
      check("reset in_ready nr14", 128'(inReady[1]), 128'(0));
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("post-reset in_ready", 128'(inReady[0]), 128'(1));

      sendBlock(0, PT_C, EXP_C1, "C1", 0, acc);
      waitDrain("C1");
      check("C1 idle in_ready", 128'(inReady[0]), 128'(1));

      ks0   = expandKey({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
      word0 = ks0[128*11-1:0];
      sendBlock(0, PT_B, EXP_B, "AppB", 0, acc);
      waitDrain("AppB");

      sendBlock(1, PT_C, EXP_C3, "C3", 0, acc);
      waitDrain("C3");

      // Backpressure: hold the result for 20 cycles while a stray block is offered.
      outReady[0] = 1'b0;
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      sendBlock(0, pt, encrypt(pt, ks0, 10), "stall", 0, acc);
      inValid[0] = 1'b1;
      inData[0]  = ~pt;
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = outValid[0];
      end
      check("stall out_valid arrives", 128'(seen), 128'(1));
      held = outData[0];
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("stall out_valid", 128'(outValid[0]), 128'(1));
         check("stall out_data", outData[0], held);
         check("stall in_ready", 128'(inReady[0]), 128'(0));
         check("stall busy", 128'(busy[0]), 128'(1));
      end
      @(posedge clk); #1;
      inValid[0]  = 1'b0;
      outReady[0] = 1'b1;
      @(posedge clk); #1;
      check("stall release in_ready", 128'(inReady[0]), 128'(1));
      check("stall release out_valid", 128'(outValid[0]), 128'(0));
      repeat (20) @(posedge clk);
      waitDrain("stall");

      // Reset during round 5 of a C.1 block.
      ks0   = expandKey({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
      word0 = ks0[128*11-1:0];
      sendBlock(0, PT_C, EXP_C1, "abort", 0, acc);
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      sbQ.delete();
      #1;
      check("abort out_valid", 128'(outValid[0]), 128'(0));
      check("abort busy", 128'(busy[0]), 128'(0));
      check("abort out_data", outData[0], 128'h0);
      check("abort in_ready", 128'(inReady[0]), 128'(0));
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("abort release in_ready", 128'(inReady[0]), 128'(1));
      sendBlock(0, PT_C, EXP_C1, "C1 after abort", 0, acc);
      waitDrain("C1 after abort");

      // Back-to-back random blocks with in_valid and out_ready held high.
      key   = {$urandom(), $urandom(), $urandom(), $urandom()};
      ks0   = expandKey({key, 128'h0}, 4);
      word0 = ks0[128*11-1:0];
      prevAcc = 0;
      for (int b = 0; b < 8; b++) begin
         pt = {$urandom(), $urandom(), $urandom(), $urandom()};
         sendBlock(0, pt, encrypt(pt, ks0, 10), $sformatf("b2b%0d", b), (b < 7), acc);
         if (b > 0) check($sformatf("b2b%0d spacing", b), 128'(acc - prevAcc), 128'(12));
         prevAcc = acc;
      end
      waitDrain("b2b");

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
